// File: rtl/mips_cpu_dmem_pkg.sv
// Shared types and constants for the pipelined CPU data memory.
package mips_cpu_dmem_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} dmem_state_t;

  localparam int MAX_READ_LATENCY = 4;
  localparam int LANES            = 4;
  localparam int LANE_W           = 8;

endpackage

// File: rtl/mips_cpu_dmem_array.sv
// Word storage built from byte-lane RAMs with per-lane write enable and registered read.
module mips_cpu_dmem_array
  import mips_cpu_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
  input  logic [LANES-1:0]               wen,
  input  logic [LANES*LANE_W-1:0]        wdata,
  input  logic                           ren,
  input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
  output logic [LANES*LANE_W-1:0]        rdata
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W-1:0] mem [DEPTH_WORDS];
    logic [LANE_W-1:0] q;

    // Read-before-write on a shared address: q gets the old byte.
    always_ff @(posedge clk) begin
      if (wen[gi]) mem[waddr] <= wdata[gi*LANE_W +: LANE_W];
      if (ren) q <= mem[raddr];
    end

    assign rdata[gi*LANE_W +: LANE_W] = q;
  end

endmodule

// File: rtl/mips_cpu_dmem_pipelined.sv
// CPU data memory with configurable read latency, waitrequest/readdatavalid handshake
// and an err pulse for misaligned or read+write requests.
module mips_cpu_dmem_pipelined
  import mips_cpu_dmem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [3:0]  byteenable,
  input  logic [31:0] writedata,
  output logic        waitrequest,
  output logic [31:0] readdata,
  output logic        readdatavalid,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(MAX_READ_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(READ_LATENCY - 1);

  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY || DEPTH_WORDS < 4 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_params
    $error("mips_cpu_dmem_pipelined: bad DEPTH_WORDS or READ_LATENCY");
  end

  dmem_state_t       state;
  logic [CW-1:0]     count;
  logic [AW-1:0]     word_index;
  logic [AW-1:0]     held_index;
  logic [AW-1:0]     raddr;
  logic              held_bad;
  logic              zero_data;
  logic              illegal;
  logic              accept;
  logic              accept_read;
  logic              commit_write;
  logic              resp_entry;
  logic              resp_bad;
  logic [LANES-1:0]  lane_wen;
  logic [31:0]       array_q;
  logic              unused_addr_bits;

  // Upper address bits are dropped so accesses wrap modulo the depth.
  assign word_index       = address[AW+1:2];
  assign unused_addr_bits = &{1'b0, address[31:AW+2]};

  assign illegal      = (address[1:0] != 2'b00) || (read && write);
  assign accept       = (read || write) && !waitrequest;
  assign accept_read  = accept && read;
  assign commit_write = accept && write && !illegal;
  assign lane_wen     = byteenable & {LANES{commit_write}};

  // The array is read on the edge that enters RESP, from the held index when leaving BUSY.
  assign resp_entry = (state == BUSY) ? (count == CW'(1)) : (accept_read && READ_LATENCY == 1);
  assign resp_bad   = (state == BUSY) ? held_bad : illegal;
  assign raddr      = (state == BUSY) ? held_index : word_index;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      count         <= '0;
      waitrequest   <= 1'b0;
      readdatavalid <= 1'b0;
      err           <= 1'b0;
      zero_data     <= 1'b1;
      held_index    <= '0;
      held_bad      <= 1'b0;
    end else begin
      err <= accept && illegal;
      if (resp_entry) zero_data <= resp_bad;
      case (state)
        BUSY: begin
          if (count == CW'(1)) begin
            state         <= RESP;
            count         <= '0;
            waitrequest   <= 1'b0;
            readdatavalid <= 1'b1;
          end else begin
            count <= count - CW'(1);
          end
        end
        default: begin
          if (accept_read) begin
            held_index <= word_index;
            held_bad   <= illegal;
            if (READ_LATENCY == 1) begin
              state         <= RESP;
              waitrequest   <= 1'b0;
              readdatavalid <= 1'b1;
            end else begin
              state         <= BUSY;
              count         <= CNT_LOAD;
              waitrequest   <= 1'b1;
              readdatavalid <= 1'b0;
            end
          end else begin
            state         <= IDLE;
            waitrequest   <= 1'b0;
            readdatavalid <= 1'b0;
          end
        end
      endcase
    end
  end

  // Illegal reads return zero; the value then holds until the next response.
  assign readdata = zero_data ? 32'h0 : array_q;

  mips_cpu_dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .waddr (word_index),
    .wen   (lane_wen),
    .wdata (writedata),
    .ren   (resp_entry),
    .raddr (raddr),
    .rdata (array_q)
  );

endmodule

// File: tb/tb_mips_cpu_dmem_pipelined.sv
// Three memories (latency 1, 3, 4) driven by directed and random traffic, checked each cycle
// against a transaction-level model of the handshake and storage.
module tb_mips_cpu_dmem_pipelined;

  logic        clk;
  logic        reset;
  logic [31:0] addr_s  [3];
  logic        rd_s    [3];
  logic        wr_s    [3];
  logic [3:0]  be_s    [3];
  logic [31:0] wd_s    [3];
  logic        wait_o  [3];
  logic        rdv_o   [3];
  logic        err_o   [3];
  logic [31:0] rdata_o [3];

  int lat [3] = '{1, 3, 4};

  int errors;
  int checks;
  int cyc;
  logic checking;

  // Model state: expected memory plus the cycle numbers at which outputs must fire.
  logic [31:0] mm [3][1024];
  int          busy_last [3];
  int          rdv_cycle [3];
  int          err_cycle [3];
  logic [31:0] rdv_data  [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? 1 : ((gi == 1) ? 3 : 4);
    mips_cpu_dmem_pipelined #(
      .DEPTH_WORDS (1024),
      .READ_LATENCY(LAT)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .address      (addr_s[gi]),
      .read         (rd_s[gi]),
      .write        (wr_s[gi]),
      .byteenable   (be_s[gi]),
      .writedata    (wd_s[gi]),
      .waitrequest  (wait_o[gi]),
      .readdata     (rdata_o[gi]),
      .readdatavalid(rdv_o[gi]),
      .err          (err_o[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: on each edge decide acceptance from the model's own busy window.
  task automatic model_edge();
    logic bad;
    int   idx;
    cyc++;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        busy_last[d] = -10;
        rdv_cycle[d] = -1;
        err_cycle[d] = -1;
      end else if ((rd_s[d] || wr_s[d]) && !((cyc - 1) <= busy_last[d])) begin
        bad = (addr_s[d][1:0] != 2'b00) || (rd_s[d] && wr_s[d]);
        idx = int'(addr_s[d][11:2]);
        if (bad) err_cycle[d] = cyc;
        if (rd_s[d]) begin
          rdv_cycle[d] = cyc + lat[d] - 1;
          busy_last[d] = cyc + lat[d] - 2;
          rdv_data[d]  = bad ? 32'h0 : mm[d][idx];
        end else if (!bad) begin
          for (int l = 0; l < 4; l++)
            if (be_s[d][l]) mm[d][idx][8*l +: 8] = wd_s[d][8*l +: 8];
        end
      end
    end
  endtask

  task automatic compare();
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        chk($sformatf("rst_wait%0d", d), 32'(wait_o[d]), 32'h0);
        chk($sformatf("rst_rdv%0d", d), 32'(rdv_o[d]), 32'h0);
        chk($sformatf("rst_err%0d", d), 32'(err_o[d]), 32'h0);
        chk($sformatf("rst_rdata%0d", d), rdata_o[d], 32'h0);
      end else begin
        chk($sformatf("wait%0d", d), 32'(wait_o[d]), 32'(cyc <= busy_last[d]));
        chk($sformatf("rdv%0d", d), 32'(rdv_o[d]), 32'(cyc == rdv_cycle[d]));
        chk($sformatf("err%0d", d), 32'(err_o[d]), 32'(cyc == err_cycle[d]));
        if (cyc == rdv_cycle[d]) chk($sformatf("rdata%0d", d), rdata_o[d], rdv_data[d]);
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (checking) compare();
  end

  // Present a request, hold it through waitrequest, release it just after the accepting edge.
  task automatic req(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [3:0] be, input logic [31:0] wd);
    int n;
    $display("dut%0d L=%0d rd=%0b wr=%0b addr=%08h be=%h wd=%08h", d, lat[d], r, w, a, be, wd);
    rd_s[d] = r; wr_s[d] = w; addr_s[d] = a; be_s[d] = be; wd_s[d] = wd;
    n = 0;
    @(negedge clk);
    while (wait_o[d] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_accept", 32'(wait_o[d]), 32'h0);
    @(posedge clk);
    #1;
    rd_s[d] = 1'b0; wr_s[d] = 1'b0;
  endtask

  task automatic read_lit(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] exp_d, input logic exp_e, input string nm);
    int n;
    int wc;
    logic e1;
    req(d, 1'b1, w, a, 4'hF, 32'h12345678);
    n = 0; wc = 0; e1 = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) e1 = err_o[d];
      if (wait_o[d]) wc++;
    end while (!rdv_o[d] && n < 12);
    chk({nm, "_lat"}, 32'(n), 32'(lat[d]));
    chk({nm, "_wait"}, 32'(wc), 32'(lat[d] - 1));
    chk({nm, "_data"}, rdata_o[d], exp_d);
    chk({nm, "_err"}, 32'(e1), 32'(exp_e));
    @(posedge clk);
    #1;
  endtask

  task automatic rand_traffic(input int d);
    logic [31:0] a;
    int op;
    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      a[11:2] = 10'($urandom_range(0, 15));
      if ($urandom_range(0, 9) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) a[31:12] = '0;
      op = $urandom_range(0, 9);
      req(d, op < 4 || op == 9, op >= 4, a, 4'($urandom), $urandom);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    repeat (6) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [31:0] vals [5];
  int seen;

  initial begin
    errors = 0; checks = 0; cyc = 0; checking = 1'b0;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      addr_s[d] = '0; rd_s[d] = 1'b0; wr_s[d] = 1'b0; be_s[d] = '0; wd_s[d] = '0;
      busy_last[d] = -10; rdv_cycle[d] = -1; err_cycle[d] = -1; rdv_data[d] = '0;
      for (int i = 0; i < 1024; i++) mm[d][i] = '0;
    end
    @(posedge clk);
    checking = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Latency 3: basic write/read, partial write, wrap, illegal requests.
    req(1, 1'b0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    read_lit(1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "basic");
    req(1, 1'b0, 1'b1, 32'h20, 4'hF, 32'h11223344);
    req(1, 1'b0, 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD);
    read_lit(1, 1'b0, 32'h20, 32'h11BB33DD, 1'b0, "partial");
    req(1, 1'b0, 1'b1, 32'h1000, 4'hF, 32'hCAFEF00D);
    read_lit(1, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "wrap");
    read_lit(1, 1'b0, 32'h13, 32'h0, 1'b1, "rd_mis");
    req(1, 1'b0, 1'b1, 32'h13, 4'hF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("wr_mis_err", 32'(err_o[1]), 32'h1);
    @(posedge clk);
    #1;
    read_lit(1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, "wr_mis_keep");
    req(1, 1'b0, 1'b1, 32'h40, 4'hF, 32'h55AA55AA);
    read_lit(1, 1'b1, 32'h40, 32'h0, 1'b1, "rdwr");
    read_lit(1, 1'b0, 32'h40, 32'h55AA55AA, 1'b0, "rdwr_keep");

    // Latency 4: reset during the second BUSY cycle discards the read.
    req(2, 1'b0, 1'b1, 32'h8, 4'hF, 32'h0BADF00D);
    req(2, 1'b1, 1'b0, 32'h8, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_wait", 32'(wait_o[2]), 32'h0);
    chk("midrst_rdv", 32'(rdv_o[2]), 32'h0);
    chk("midrst_data", rdata_o[2], 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (rdv_o[2]) seen++;
    end
    chk("midrst_no_rdv", 32'(seen), 32'h0);
    @(posedge clk);
    #1;
    read_lit(2, 1'b0, 32'h8, 32'h0BADF00D, 1'b0, "midrst_keep");

    // Latency 1: five back-to-back reads.
    for (int k = 0; k < 5; k++) begin
      vals[k] = 32'hA5000000 + 32'(k * 17);
      req(0, 1'b0, 1'b1, 32'h100 + 32'(k * 4), 4'hF, vals[k]);
    end
    for (int k = 0; k < 5; k++) begin
      $display("dut0 L=1 stream read addr=%08h", 32'h100 + 32'(k * 4));
      rd_s[0] = 1'b1; addr_s[0] = 32'h100 + 32'(k * 4);
      @(negedge clk);
      chk("stream_wait", 32'(wait_o[0]), 32'h0);
      if (k > 0) begin
        chk("stream_rdv", 32'(rdv_o[0]), 32'h1);
        chk("stream_data", rdata_o[0], vals[k-1]);
      end
      @(posedge clk);
      #1;
    end
    rd_s[0] = 1'b0;
    @(negedge clk);
    chk("stream_rdv_last", 32'(rdv_o[0]), 32'h1);
    chk("stream_data_last", rdata_o[0], vals[4]);
    @(posedge clk);
    #1;

    for (int d = 0; d < 3; d++) rand_traffic(d);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
